// File: rtl/pipe_pkg.sv
// Shared types for the inter-stage pipeline latches.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKIDF = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/pipeline_latch.sv
// Generic inter-stage pipeline register: valid/ready handshake, global advance, flush-to-NOP,
// optional one-entry skid buffer so in_ready can come straight from a flop.
module pipeline_latch
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH = 32,
    parameter logic [WIDTH-1:0] NOP   = '0,
    parameter bit               SKID  = 1'b1,
    parameter int unsigned      CNTW  = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy,
    output logic [CNTW-1:0]  stall_cnt
);

    pipe_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             acc, pop, stall;

    // SKID=1 decouples in_ready from out_ready; SKID=0 lets a pop make room in the same cycle.
    if (SKID) begin : g_skid
        assign in_ready = (state_q != SKIDF);
    end else begin : g_noskid
        assign in_ready = (state_q == EMPTY) | out_ready;
    end

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign stall_cnt = cnt_q;

    assign acc   = en & in_valid & in_ready;
    assign pop   = en & out_valid & out_ready;
    assign stall = en & out_valid & ~out_ready & ~flush;

    always_comb begin
        occupancy = 2'd0;
        unique case (state_q)
            EMPTY:   occupancy = 2'd0;
            FULL:    occupancy = 2'd1;
            SKIDF:   occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (en && flush) begin
            state_d = EMPTY;
            main_d  = NOP;
            skid_d  = NOP;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        main_d  = in_data;
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (acc && pop) begin
                        main_d = in_data;
                    end else if (acc) begin
                        skid_d  = in_data;
                        state_d = SKIDF;
                    end else if (pop) begin
                        main_d  = NOP;
                        state_d = EMPTY;
                    end
                end
                SKIDF: begin
                    if (pop) begin
                        main_d  = skid_q;
                        skid_d  = NOP;
                        state_d = FULL;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = NOP;
                    skid_d  = NOP;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNTW{1'b1}})) begin
            cnt_d = cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= EMPTY;
            main_q  <= NOP;
            skid_q  <= NOP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_latch.sv
// Self-checking bench for pipeline_latch: one SKID=1 and one SKID=0 instance on shared inputs.
module tb_pipeline_latch;

    localparam logic [7:0] NOP_S = 8'hE5;
    localparam logic [7:0] NOP_N = 8'h5A;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       en, flush, in_valid, out_ready;
    logic [7:0] in_data;

    logic       s_in_ready, s_out_valid;
    logic [7:0] s_out_data;
    logic [1:0] s_occ;
    logic [3:0] s_cnt;
    logic       n_in_ready, n_out_valid;
    logic [7:0] n_out_data;
    logic [1:0] n_occ;
    logic [7:0] n_cnt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    pipeline_latch #(.WIDTH(8), .NOP(NOP_S), .SKID(1'b1), .CNTW(4)) u_skid (
        .CLK(CLK), .nRST(nRST), .en(en), .flush(flush), .in_valid(in_valid),
        .in_data(in_data), .in_ready(s_in_ready), .out_valid(s_out_valid),
        .out_data(s_out_data), .out_ready(out_ready), .occupancy(s_occ), .stall_cnt(s_cnt)
    );

    pipeline_latch #(.WIDTH(8), .NOP(NOP_N), .SKID(1'b0), .CNTW(8)) u_noskid (
        .CLK(CLK), .nRST(nRST), .en(en), .flush(flush), .in_valid(in_valid),
        .in_data(in_data), .in_ready(n_in_ready), .out_valid(n_out_valid),
        .out_data(n_out_data), .out_ready(out_ready), .occupancy(n_occ), .stall_cnt(n_cnt)
    );

    // {out_valid, in_ready, occupancy, out_data, stall_cnt}
    function automatic logic [19:0] pk(input logic ov, input logic ir, input logic [1:0] oc,
                                       input logic [7:0] d, input logic [7:0] c);
        return {ov, ir, oc, d, c};
    endfunction

    task automatic chk(input string nm, input logic [19:0] act, input logic [19:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic e, input logic f, input logic iv, input logic [7:0] d,
                         input logic r);
        en = e; flush = f; in_valid = iv; in_data = d; out_ready = r;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        nRST = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b1;
    endtask

    typedef struct packed {
        logic       en, fl, iv;
        logic [7:0] d;
        logic       ordy;
        logic       ov, irdy;
        logic [1:0] occ;
        logic [7:0] od;
        logic [3:0] cnt;
    } vec_t;

    vec_t tbl [18];

    logic [7:0] qs[$], qn[$];
    int         cs, cn;
    logic       m_irdy_s, m_irdy_n, acc_m, pop_m;

    initial begin
        // inputs applied for one edge; outputs expected just after that edge (SKID=1 instance)
        tbl[0]  = '{1,0,1,8'h11,1, 1,1,2'd1,8'h11,4'd0};
        tbl[1]  = '{1,0,1,8'h22,1, 1,1,2'd1,8'h22,4'd0};
        tbl[2]  = '{1,0,1,8'h33,1, 1,1,2'd1,8'h33,4'd0};
        tbl[3]  = '{1,0,0,8'h00,1, 0,1,2'd0,NOP_S,4'd0};
        tbl[4]  = '{1,0,1,8'h0A,0, 1,1,2'd1,8'h0A,4'd0};
        tbl[5]  = '{1,0,1,8'h0B,0, 1,0,2'd2,8'h0A,4'd1};
        tbl[6]  = '{1,0,1,8'h0C,0, 1,0,2'd2,8'h0A,4'd2};
        tbl[7]  = '{1,0,0,8'h00,1, 1,1,2'd1,8'h0B,4'd2};
        tbl[8]  = '{1,0,0,8'h00,1, 0,1,2'd0,NOP_S,4'd2};
        tbl[9]  = '{1,0,1,8'h44,0, 1,1,2'd1,8'h44,4'd2};
        tbl[10] = '{0,1,1,8'h55,1, 1,1,2'd1,8'h44,4'd2};
        tbl[11] = '{0,1,1,8'h56,1, 1,1,2'd1,8'h44,4'd2};
        tbl[12] = '{0,1,1,8'h57,1, 1,1,2'd1,8'h44,4'd2};
        tbl[13] = '{1,0,0,8'h00,0, 1,1,2'd1,8'h44,4'd3};
        tbl[14] = '{1,0,1,8'h05,1, 1,1,2'd1,8'h05,4'd3};
        tbl[15] = '{1,0,1,8'h06,0, 1,0,2'd2,8'h05,4'd4};
        tbl[16] = '{1,1,1,8'h07,0, 0,1,2'd0,NOP_S,4'd4};
        tbl[17] = '{1,0,0,8'h00,1, 0,1,2'd0,NOP_S,4'd4};

        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        nRST = 1'b0;
        #12;
        chk("reset_skid", pk(s_out_valid, s_in_ready, s_occ, s_out_data, {4'd0, s_cnt}),
            pk(1'b0, 1'b1, 2'd0, NOP_S, 8'd0));
        chk("reset_noskid", pk(n_out_valid, n_in_ready, n_occ, n_out_data, n_cnt),
            pk(1'b0, 1'b1, 2'd0, NOP_N, 8'd0));
        @(posedge CLK); #1;
        nRST = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].en, tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            @(posedge CLK); #1;
            chk($sformatf("vec%0d", i),
                pk(s_out_valid, s_in_ready, s_occ, s_out_data, {4'd0, s_cnt}),
                pk(tbl[i].ov, tbl[i].irdy, tbl[i].occ, tbl[i].od, {4'd0, tbl[i].cnt}));
        end

        // SKID=0: same-cycle back-pressure and replace-on-pop
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 8'h21, 1'b1);
        @(posedge CLK); #1;
        out_ready = 1'b0;
        #1;
        chk("noskid_bp_low", {19'd0, n_in_ready}, 20'd0);
        out_ready = 1'b1;
        #1;
        chk("noskid_bp_high", {19'd0, n_in_ready}, 20'd1);
        in_data = 8'h31;
        @(posedge CLK); #1;
        chk("noskid_replace", pk(n_out_valid, 1'b0, n_occ, n_out_data, n_cnt),
            pk(1'b1, 1'b0, 2'd1, 8'h31, 8'd0));

        // saturate the stall counter, then pulse reset between edges
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 8'h77, 1'b0);
        repeat (20) @(posedge CLK);
        #1;
        chk("sat_cnt", pk(s_out_valid, s_in_ready, s_occ, s_out_data, {4'd0, s_cnt}),
            pk(1'b1, 1'b0, 2'd2, 8'h77, 8'd15));
        #2 nRST = 1'b0;
        #1;
        chk("async_rst_skid", pk(s_out_valid, s_in_ready, s_occ, s_out_data, {4'd0, s_cnt}),
            pk(1'b0, 1'b1, 2'd0, NOP_S, 8'd0));
        chk("async_rst_noskid", pk(n_out_valid, n_in_ready, n_occ, n_out_data, n_cnt),
            pk(1'b0, 1'b1, 2'd0, NOP_N, 8'd0));
        #3 nRST = 1'b1;

        // randomized run against FIFO-queue reference models
        do_reset();
        qs.delete(); qn.delete(); cs = 0; cn = 0;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 6);
            #1;
            m_irdy_s = (qs.size() < 2);
            m_irdy_n = (qn.size() == 0) || out_ready;
            chk("rand_irdy_s", {19'd0, s_in_ready}, {19'd0, m_irdy_s});
            chk("rand_irdy_n", {19'd0, n_in_ready}, {19'd0, m_irdy_n});
            if (en) begin
                if (flush) begin
                    qs.delete(); qn.delete();
                end else begin
                    acc_m = in_valid && m_irdy_s;
                    pop_m = (qs.size() > 0) && out_ready;
                    if (qs.size() > 0 && !out_ready && cs < 15) cs++;
                    if (pop_m) void'(qs.pop_front());
                    if (acc_m) qs.push_back(in_data);
                    acc_m = in_valid && m_irdy_n;
                    pop_m = (qn.size() > 0) && out_ready;
                    if (qn.size() > 0 && !out_ready && cn < 255) cn++;
                    if (pop_m) void'(qn.pop_front());
                    if (acc_m) qn.push_back(in_data);
                end
            end
            @(posedge CLK); #1;
            chk($sformatf("rand_s%0d", i),
                pk(s_out_valid, 1'b0, s_occ, s_out_data, {4'd0, s_cnt}),
                pk(qs.size() > 0, 1'b0, 2'(qs.size()), (qs.size() > 0) ? qs[0] : NOP_S,
                   8'(cs)));
            chk($sformatf("rand_n%0d", i),
                pk(n_out_valid, 1'b0, n_occ, n_out_data, n_cnt),
                pk(qn.size() > 0, 1'b0, 2'(qn.size()), (qn.size() > 0) ? qn[0] : NOP_N,
                   8'(cn)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
